ternary_iid_sampler: RTL and testbench
======================================

Name: ternary_iid_sampler

Overview:
Downstream consumer of the 8-bit random coin stream produced by the LFSR stage in the NTRU-HRSS random path. Implements sample_iid: each coin byte is reduced mod 3 to give one ternary coefficient. The first N-1 coefficients come from coins; coefficient N-1 is forced to 0. Coefficients stream out one per accepted coin to the polynomial buffer / key-gen datapath.

Parameters:
N, 701, polynomial length; N-1 coefficients sampled, coefficient N-1 fixed at 0
IDX_W, 10, width of coefficient index; must satisfy 2^IDX_W > N-1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a new polynomial when idle
coin  in  8  random byte from upstream
coin_valid  in  1  coin is valid this cycle
coin_ready  out  1  sampler accepts coin this cycle
coef  out  2  ternary coefficient, values 0/1/2 only
coef_idx  out  IDX_W  index of coef, 0..N-1
coef_valid  out  1  coef/coef_idx valid
coef_ready  in  1  downstream accepts coef this cycle
coef_last  out  1  high with coef_valid when coef_idx == N-1
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after coefficient N-1 is accepted

Behaviour:
- Clock clk, reset rst. Reset is asynchronous and active-high. All state registers clear on rst assertion, regardless of clk.
- Reset values: state=IDLE, coef=0, coef_idx=0, coef_valid=0, coef_last=0, done=0, busy=0, internal counter=0. coin_ready=0 while in IDLE.
- Coin transfer: coin_valid && coin_ready at a rising edge. Coef transfer: coef_valid && coef_ready at a rising edge.
- coin_ready = (state==SAMPLE) && (!coef_valid || coef_ready). This is combinational from registered state plus coef_ready. It is not a function of coin_valid.
- Latency: a coin accepted at edge k drives coef_valid=1 with coef=coin mod 3 immediately after edge k. coef_idx equals the count of coins accepted before it.
- coef, coef_idx and coef_last hold stable while coef_valid && !coef_ready. No coefficient is dropped or duplicated.
- Reduction: coef = unsigned coin mod 3, exact over 0..255. Examples: 0->0, 1->1, 2->2, 3->0, 254->2, 255->0. The value 3 is never produced.
- FSM:
  - IDLE: start -> SAMPLE, counter=0. All other inputs ignored.
  - SAMPLE: each accepted coin increments the counter. When the (N-1)th coin is accepted (counter == N-2 at acceptance), go to PAD.
  - PAD: coin_ready=0. When the output register is free (!coef_valid || coef_ready), load coef=0, coef_idx=N-1, coef_last=1, coef_valid=1, then go to FLUSH.
  - FLUSH: wait for the coef_last transfer. On that edge: coef_valid=0, done=1 for exactly one cycle, then IDLE.
- start while busy: ignored; no restart and no counter change.
- coin_valid while not SAMPLE: ignored; no coin is consumed.
- rst mid-polynomial: everything aborts immediately; no done pulse; the next start begins again at index 0.
- Back-to-back polynomials: start may be asserted in the cycle done is high. That start is accepted because state is IDLE.
- Throughput: one coefficient per cycle when coin_valid=1 and coef_ready=1 continuously. One polynomial completes in N coefficient transfers.

Decomposition:
- Shared package ntru_pkg: N, IDX_W, state enum typedef (IDLE, SAMPLE, PAD, FLUSH), 2-bit trit typedef.
- One sub-module: mod3_u8, a combinational 8-bit -> 2-bit exact remainder. Use bit-pair folding, not a divider. Verify it standalone over all 256 inputs.

Test Plan:
- mod3_u8 exhaustive: inputs 0..255 -> output equals i%3; output never 3.
- Full run, LFSR upstream seeded 255, coef_ready=1: start -> exactly 701 coef transfers, indices 0..700 in order. coef_last only at idx 700 with coef=0. done pulses once, 1 cycle after that transfer. The first coin (255) gives coef=0 at idx 0.
- Backpressure: coef_ready toggles 1,0,0,1 continuously. coef/coef_idx stay stable while stalled, and coin_ready=0 during stalls. The sequence matches a software mod-3 model of the coin stream byte for byte.
- Coin starvation: coin_valid low for 5 cycles at idx 350 -> coef_valid drops after the idx-349 transfer, no index skips, busy stays 1, and the run resumes at 350.
- Reset mid-run: assert rst asynchronously (between edges) at idx 123 -> all outputs 0 without waiting for a clock edge, no done. A subsequent start restarts at idx 0.
- start while busy at idx 10 and during PAD -> ignored, and the total transfer count is still 701. A start coincident with done launches the next polynomial at idx 0.

Source files
------------

// File: rtl/ntru_pkg.sv
// Shared constants and types for the NTRU-HRSS ternary sampling path.
package ntru_pkg;

    localparam int unsigned N      = 701;
    localparam int unsigned IDX_W  = 10;
    localparam int unsigned COIN_W = 8;

    typedef logic [1:0] trit_t;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        PAD,
        FLUSH
    } state_e;

    // Index of the forced-zero coefficient, and the counter value whose coin completes sampling.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] PAD_TRIG = IDX_W'(N - 2);

endpackage

// File: rtl/ternary_iid_sampler_if.sv
// Coin input and coefficient output handshakes of the ternary sampler.
interface ternary_iid_sampler_if;
    import ntru_pkg::*;

    logic [COIN_W-1:0] coin;
    logic              coin_valid;
    logic              coin_ready;
    trit_t             coef;
    logic [IDX_W-1:0]  coef_idx;
    logic              coef_valid;
    logic              coef_ready;
    logic              coef_last;

    modport master (
        output coin, coin_valid, coef_ready,
        input  coin_ready, coef, coef_idx, coef_valid, coef_last
    );

    modport slave (
        input  coin, coin_valid, coef_ready,
        output coin_ready, coef, coef_idx, coef_valid, coef_last
    );

endinterface

// File: rtl/mod3_u8.sv
// Exact unsigned 8-bit remainder mod 3 by base-4 digit folding (4 == 1 mod 3).
module mod3_u8
    import ntru_pkg::*;
(
    input  logic [COIN_W-1:0] x_i,
    output trit_t             r_o
);

    logic [3:0] sum4;
    logic [2:0] sum3;
    logic [2:0] sum2;
    logic [1:0] sum1;

    always_comb begin
        sum4 = 4'(x_i[1:0]) + 4'(x_i[3:2]) + 4'(x_i[5:4]) + 4'(x_i[7:6]);
        sum3 = 3'(sum4[3:2]) + 3'(sum4[1:0]);
        sum2 = 3'(sum3[2]) + 3'(sum3[1:0]);
        sum1 = 2'(sum2[2]) + sum2[1:0];
        // sum1 is 0..3 and congruent to x_i; fold the single remaining 3 to 0.
        r_o  = (sum1 == 2'd3) ? 2'd0 : sum1;
    end

endmodule

// File: rtl/ternary_iid_sampler.sv
// sample_iid: reduces each coin byte mod 3 into one coefficient, then appends a zero at index N-1.
module ternary_iid_sampler
    import ntru_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    ternary_iid_sampler_if.slave  bus,
    output logic                  busy,
    output logic                  done
);

    state_e           state_q;
    logic [IDX_W-1:0] cnt_q;
    trit_t            coef_q;
    logic [IDX_W-1:0] idx_q;
    logic             valid_q;
    logic             last_q;
    logic             done_q;
    logic             busy_q;

    trit_t            coin_mod3;
    logic             out_free;
    logic             coin_ready_c;
    logic             coin_xfer;
    logic             coef_xfer;

    mod3_u8 u_mod3 (
        .x_i (bus.coin),
        .r_o (coin_mod3)
    );

    // Output register can take a new value when empty or being drained this cycle.
    assign out_free     = !valid_q || bus.coef_ready;
    assign coin_ready_c = (state_q == SAMPLE) && out_free;
    assign coin_xfer    = coin_ready_c && bus.coin_valid;
    assign coef_xfer    = valid_q && bus.coef_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            coef_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SAMPLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SAMPLE: begin
                    if (coin_xfer) begin
                        coef_q  <= coin_mod3;
                        idx_q   <= cnt_q;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                        cnt_q   <= cnt_q + IDX_W'(1);
                        if (cnt_q == PAD_TRIG) begin
                            state_q <= PAD;
                        end
                    end else if (coef_xfer) begin
                        valid_q <= 1'b0;
                    end
                end
                PAD: begin
                    if (out_free) begin
                        coef_q  <= '0;
                        idx_q   <= LAST_IDX;
                        last_q  <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (coef_xfer) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.coin_ready = coin_ready_c;
    assign bus.coef       = coef_q;
    assign bus.coef_idx   = idx_q;
    assign bus.coef_valid = valid_q;
    assign bus.coef_last  = last_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_ternary_iid_sampler.sv
// Directed bench for ternary_iid_sampler and its mod3_u8 reducer.
module tb_ternary_iid_sampler;
    import ntru_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    logic  start;
    logic  busy;
    logic  done;
    logic [7:0] m3_x;
    trit_t m3_r;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] coins [0:N-2];

    ternary_iid_sampler_if bus ();

    ternary_iid_sampler dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    mod3_u8 u_m3 (
        .x_i (m3_x),
        .r_o (m3_r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_coef(input int k);
        if (k >= int'(N) - 1) return 0;
        return int'(coins[k]) % 3;
    endfunction

    // Outputs must all read zero while rst is high, before any clock edge.
    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, bus.coef_valid, 0);
        check({tag, "_coef"}, bus.coef, 0);
        check({tag, "_idx"}, bus.coef_idx, 0);
        check({tag, "_last"}, bus.coef_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_coin_ready"}, bus.coin_ready, 0);
    endtask

    // One polynomial; called and returns at posedge+2.
    task automatic run_poly(input int rdy_mode, input int starve_at, input bit busy_starts,
                            input int abort_at, input bit skip_start, input bit chain);
        int ptr, xfers, cyc, starve_cnt, phase;
        bit pend_last, prev_stall, st10, stpad, fin;
        logic [1:0] h_coef;
        logic [IDX_W-1:0] h_idx;
        logic h_last;
        ptr = 0; xfers = 0; cyc = 0; starve_cnt = 0; phase = 0;
        pend_last = 0; prev_stall = 0; st10 = 0; stpad = 0; fin = 0;
        h_coef = '0; h_idx = '0; h_last = 1'b0;
        if (!skip_start) begin
            start = 1'b1;
            @(posedge clk); #2;
            start = 1'b0;
        end
        check("busy_after_start", busy, 1);
        while (!fin && cyc < 6000) begin
            if (pend_last) begin
                check("done_pulse", done, 1);
                check("busy_cleared", busy, 0);
                check("valid_cleared", bus.coef_valid, 0);
                if (chain) begin
                    start = 1'b1;
                    @(posedge clk); #2;
                    start = 1'b0;
                end else begin
                    @(posedge clk); #2;
                    check("done_single", done, 0);
                end
                fin = 1;
            end else begin
                check("done_low", done, 0);
                if (prev_stall) begin
                    check("hold_valid", bus.coef_valid, 1);
                    check("hold_coef", bus.coef, h_coef);
                    check("hold_idx", bus.coef_idx, h_idx);
                    check("hold_last", bus.coef_last, h_last);
                end
                bus.coef_ready = (rdy_mode == 0) ? 1'b1 : ((phase % 4 == 0) || (phase % 4 == 3));
                start = 1'b0;
                if (busy_starts && xfers == 10 && !st10) begin start = 1'b1; st10 = 1; end
                if (busy_starts && ptr == int'(N) - 1 && !stpad) begin start = 1'b1; stpad = 1; end
                if (starve_at >= 0 && ptr == starve_at && starve_cnt < 5) begin
                    bus.coin_valid = 1'b0;
                    starve_cnt++;
                    if (starve_cnt >= 2) begin
                        check("starve_valid_low", bus.coef_valid, 0);
                        check("starve_busy", busy, 1);
                    end
                end else begin
                    bus.coin_valid = 1'b1;
                end
                bus.coin = coins[(ptr < int'(N) - 1) ? ptr : int'(N) - 2];
                #1;
                if (ptr == int'(N) - 1) check("coin_ready_after_last_coin", bus.coin_ready, 0);
                if (bus.coef_valid && !bus.coef_ready) check("stall_coin_ready", bus.coin_ready, 0);
                prev_stall = bus.coef_valid && !bus.coef_ready;
                h_coef = bus.coef; h_idx = bus.coef_idx; h_last = bus.coef_last;
                if (bus.coef_valid && bus.coef_ready) begin
                    check("coef", bus.coef, exp_coef(xfers));
                    check("idx", bus.coef_idx, xfers);
                    check("last", bus.coef_last, (xfers == int'(N) - 1) ? 1 : 0);
                    if (xfers == 0) check("first_coef_of_255", bus.coef, 0);
                    if (xfers == int'(N) - 1) pend_last = 1;
                    xfers++;
                end
                if (bus.coin_valid && bus.coin_ready) ptr++;
                if (abort_at >= 0 && xfers == abort_at) begin
                    #3;
                    rst = 1'b1;
                    #1;
                    check_reset_outputs("abort");
                    @(posedge clk); #2;
                    check("abort_no_done", done, 0);
                    rst = 1'b0;
                    @(posedge clk); #2;
                    check("abort_idle_busy", busy, 0);
                    check("abort_idle_done", done, 0);
                    fin = 1;
                end else begin
                    @(posedge clk); #2;
                    cyc++;
                    phase++;
                end
            end
        end
        check("run_finished", fin, 1);
        if (abort_at < 0) check("total_xfers", xfers, N);
        bus.coin_valid = 1'b0;
        bus.coef_ready = 1'b1;
    endtask

    initial begin
        logic [7:0] lfsr;
        logic [7:0] spot_in [0:7];
        int         spot_exp [0:7];
        rst = 1'b1; start = 1'b0; m3_x = '0;
        bus.coin = '0; bus.coin_valid = 1'b0; bus.coef_ready = 1'b0;

        // Upstream Galois LFSR (x^8+x^6+x^5+x^4+1), seeded 255.
        lfsr = 8'hFF;
        for (int i = 0; i < int'(N) - 1; i++) begin
            coins[i] = lfsr;
            lfsr = lfsr[0] ? ((lfsr >> 1) ^ 8'hB8) : (lfsr >> 1);
        end

        spot_in  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd254, 8'd255, 8'd128, 8'd100};
        spot_exp = '{0, 1, 2, 0, 2, 0, 2, 1};
        for (int i = 0; i < 8; i++) begin
            m3_x = spot_in[i];
            #1;
            check("mod3_spot", m3_r, spot_exp[i]);
        end
        for (int i = 0; i < 256; i++) begin
            m3_x = 8'(i);
            #1;
            check("mod3_all", m3_r, i % 3);
        end

        #3;
        check_reset_outputs("reset");
        bus.coef_ready = 1'b1;
        #1;
        check("reset_coin_ready_rdy", bus.coin_ready, 0);
        #4;
        rst = 1'b0;
        @(posedge clk); #2;

        // Coins offered while idle must not be taken.
        bus.coin_valid = 1'b1;
        bus.coin = 8'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("idle_coin_ready", bus.coin_ready, 0);
            check("idle_busy", busy, 0);
            @(posedge clk); #1;
        end
        bus.coin_valid = 1'b0;
        @(posedge clk); #2;

        run_poly(0, -1, 1'b0, -1, 1'b0, 1'b0);
        run_poly(1, -1, 1'b0, -1, 1'b0, 1'b0);
        run_poly(0, 350, 1'b0, -1, 1'b0, 1'b0);
        run_poly(0, -1, 1'b0, 123, 1'b0, 1'b0);
        run_poly(0, -1, 1'b1, -1, 1'b0, 1'b1);
        run_poly(0, -1, 1'b0, -1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
